// File: rtl/load_store_unit.sv
// Load/store unit: computes the effective address, runs one memory micro-op at a time
// (read-modify-write for sub-word stores) and returns a single registered response.
module load_store_unit #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_base,
    input  logic [11:0] req_offset,
    input  logic [31:0] req_store_data,
    input  logic [4:0]  req_rd,
    input  logic        flush,
    output logic        mem_read_en,
    output logic        mem_write_en,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic        resp_valid,
    output logic        resp_is_store,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        resp_fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MERGE,
        S_WRITE,
        S_FAULT
    } state_t;

    state_t      r_state;
    logic        r_ready;
    logic        r_rd_en;
    logic        r_wr_en;
    logic [31:0] r_ea;
    logic [2:0]  r_funct3;
    logic        r_is_store;
    logic [4:0]  r_rd;
    logic [31:0] r_wdata;
    logic        r_resp_valid;
    logic        r_resp_is_store;
    logic [31:0] r_resp_data;
    logic [4:0]  r_resp_rd;
    logic        r_resp_fault;

    logic [31:0] w_ea;
    logic        w_misalign;
    logic        w_illegal;
    logic        w_range;
    logic        w_fault;
    logic        w_accept;

    // funct3[1:0] encodes the access size; funct3[2] marks an unsigned load.
    function automatic logic [31:0] f_extend(input logic [31:0] word, input logic [1:0] size,
                                             input logic uns, input logic [1:0] lane);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (size)
            2'b00:   f_extend = uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   f_extend = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: f_extend = word;
        endcase
    endfunction

    function automatic logic [31:0] f_merge(input logic [31:0] word, input logic [31:0] data,
                                            input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] mask;
        logic [31:0] ins;
        mask = (size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
        mask = mask << {lane, 3'b000};
        ins  = data << {lane, 3'b000};
        f_merge = (word & ~mask) | (ins & mask);
    endfunction

    assign w_ea = req_base + {{20{req_offset[11]}}, req_offset};

    always_comb begin
        w_misalign = 1'b0;
        case (req_funct3[1:0])
            2'b01:   w_misalign = w_ea[0];
            2'b10:   w_misalign = |w_ea[1:0];
            default: w_misalign = 1'b0;
        endcase
    end

    assign w_illegal = req_is_store ? (req_funct3[2] | (&req_funct3[1:0]))
                                    : ((&req_funct3[1:0]) | (req_funct3 == 3'b110));
    assign w_range   = (w_ea[31:2] >= 30'(MEM_WORDS));
    assign w_fault   = w_misalign | w_illegal | w_range;
    assign w_accept  = req_valid & r_ready & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= S_IDLE;
            r_ready         <= 1'b1;
            r_rd_en         <= 1'b0;
            r_wr_en         <= 1'b0;
            r_ea            <= '0;
            r_funct3        <= '0;
            r_is_store      <= 1'b0;
            r_rd            <= '0;
            r_wdata         <= '0;
            r_resp_valid    <= 1'b0;
            r_resp_is_store <= 1'b0;
            r_resp_data     <= '0;
            r_resp_rd       <= '0;
            r_resp_fault    <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_fault <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ea       <= w_ea;
                        r_funct3   <= req_funct3;
                        r_is_store <= req_is_store;
                        r_rd       <= req_rd;
                        r_wdata    <= req_store_data;
                        r_ready    <= 1'b0;
                        if (w_fault) begin
                            r_state <= S_FAULT;
                        end else if (!req_is_store) begin
                            r_state <= S_LOAD;
                            r_rd_en <= 1'b1;
                        end else if (req_funct3[1:0] == 2'b10) begin
                            r_state <= S_WRITE;
                            r_wr_en <= 1'b1;
                        end else begin
                            r_state <= S_MERGE;
                            r_rd_en <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_rd_en <= 1'b0;
                    if (!flush) begin
                        r_resp_valid    <= 1'b1;
                        r_resp_is_store <= 1'b0;
                        r_resp_rd       <= r_rd;
                        r_resp_data     <= f_extend(mem_read_data, r_funct3[1:0], r_funct3[2], r_ea[1:0]);
                    end
                end
                S_MERGE: begin
                    r_rd_en <= 1'b0;
                    if (flush) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                    end else begin
                        r_state <= S_WRITE;
                        r_wr_en <= 1'b1;
                        r_wdata <= f_merge(mem_read_data, r_wdata, r_funct3[1:0], r_ea[1:0]);
                    end
                end
                // The write is already committed at this edge, so a flush cannot cancel it.
                S_WRITE: begin
                    r_state         <= S_IDLE;
                    r_ready         <= 1'b1;
                    r_wr_en         <= 1'b0;
                    r_resp_valid    <= 1'b1;
                    r_resp_is_store <= 1'b1;
                    r_resp_rd       <= r_rd;
                    r_resp_data     <= '0;
                end
                S_FAULT: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    if (!flush) begin
                        r_resp_valid    <= 1'b1;
                        r_resp_fault    <= 1'b1;
                        r_resp_is_store <= r_is_store;
                        r_resp_rd       <= r_rd;
                        r_resp_data     <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_rd_en <= 1'b0;
                    r_wr_en <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready      = r_ready;
    assign mem_read_en    = r_rd_en;
    assign mem_write_en   = r_wr_en;
    assign mem_address    = {2'b00, r_ea[31:2]};
    assign mem_write_data = r_wdata;
    assign resp_valid     = r_resp_valid;
    assign resp_is_store  = r_resp_is_store;
    assign resp_data      = r_resp_data;
    assign resp_rd        = r_resp_rd;
    assign resp_fault     = r_resp_fault;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, flush/reset sequences and random
// operations checked against a word-array reference model.
module tb_load_store_unit;
    localparam int MEM_WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_base;
    logic [11:0] req_offset;
    logic [31:0] req_store_data;
    logic [4:0]  req_rd;
    logic        flush;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        resp_valid;
    logic        resp_is_store;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_fault;

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
        .req_store_data(req_store_data), .req_rd(req_rd), .flush(flush),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .resp_valid(resp_valid), .resp_is_store(resp_is_store), .resp_data(resp_data),
        .resp_rd(resp_rd), .resp_fault(resp_fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] tb_mem  [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    logic        fill;
    int          rd_total = 0;
    int          wr_total = 0;
    int          both_total = 0;
    logic [31:0] last_wr_addr = '0;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h0100_0193) ^ 32'hA5A5_0F0F;
    endfunction

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < MEM_WORDS; i++) tb_mem[i] <= init_word(i);
        end else if (mem_write_en) begin
            tb_mem[mem_address[9:0]] <= mem_write_data;
        end
    end
    assign mem_read_data = tb_mem[mem_address[9:0]];

    always @(negedge clk) begin
        if (rst) begin
            if (mem_read_en) rd_total <= rd_total + 1;
            if (mem_write_en) begin
                wr_total     <= wr_total + 1;
                last_wr_addr <= mem_address;
            end
            if (mem_read_en && mem_write_en) both_total <= both_total + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Reference: byte-addressed view of a word array, plain size/alignment arithmetic.
    task automatic model_op(input logic st, input logic [2:0] f3, input logic [31:0] base,
                            input logic [11:0] off, input logic [31:0] sd,
                            output logic flt, output logic [31:0] data, output int lat);
        logic [31:0] ea;
        logic [31:0] mask;
        int size, sh, widx;
        bit sgn;
        ea = base + {{20{off[11]}}, off};
        size = 0;
        sgn = 0;
        if (!st) begin
            case (f3)
                3'd0: begin size = 1; sgn = 1; end
                3'd1: begin size = 2; sgn = 1; end
                3'd2: size = 4;
                3'd4: size = 1;
                3'd5: size = 2;
                default: size = 0;
            endcase
        end else begin
            case (f3)
                3'd0: size = 1;
                3'd1: size = 2;
                3'd2: size = 4;
                default: size = 0;
            endcase
        end
        flt = (size == 0) || (size == 2 && ea[0]) || (size == 4 && ea[1:0] != 2'b00)
              || ((ea / 4) >= MEM_WORDS);
        data = '0;
        lat = 2;
        if (!flt) begin
            widx = int'(ea / 4);
            sh = 8 * int'(ea % 4);
            mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
            if (!st) begin
                data = (ref_mem[widx] >> sh) & mask;
                if (sgn && size < 4 && data[8 * size - 1]) data = data | ~mask;
            end else begin
                ref_mem[widx] = (ref_mem[widx] & ~(mask << sh)) | ((sd & mask) << sh);
                if (size < 4) lat = 3;
            end
        end
    endtask

    task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] base,
                         input logic [11:0] off, input logic [31:0] sd, input logic [4:0] rd);
        req_valid      = 1'b1;
        req_is_store   = st;
        req_funct3     = f3;
        req_base       = base;
        req_offset     = off;
        req_store_data = sd;
        req_rd         = rd;
    endtask

    // Called at a negedge with the unit idle; returns at the negedge where resp_valid is seen.
    task automatic run_op(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] base, input logic [11:0] off, input logic [31:0] sd,
                          input logic [4:0] rd, input logic exp_flt, input logic [31:0] exp_data,
                          input int exp_lat);
        int rd0, wr0, both0, cyc, exp_rd_cnt, exp_wr_cnt;
        bit seen;
        logic [31:0] ea;
        ea = base + {{20{off[11]}}, off};
        check({tag, ".ready"}, req_ready, 1);
        rd0 = rd_total; wr0 = wr_total; both0 = both_total;
        drive(st, f3, base, off, sd, rd);
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        seen = 0;
        while (!seen && cyc < 8) begin
            @(negedge clk);
            cyc++;
            if (resp_valid) seen = 1;
        end
        check({tag, ".resp_seen"}, seen, 1);
        if (seen) begin
            check({tag, ".latency"}, cyc, exp_lat);
            check({tag, ".fault"}, resp_fault, exp_flt);
            check({tag, ".data"}, resp_data, exp_data);
            check({tag, ".rd"}, resp_rd, rd);
            check({tag, ".is_store"}, resp_is_store, st);
        end
        exp_rd_cnt = (!exp_flt && (!st || f3 != 3'd2)) ? 1 : 0;
        exp_wr_cnt = (!exp_flt && st) ? 1 : 0;
        check({tag, ".rd_cycles"}, rd_total - rd0, exp_rd_cnt);
        check({tag, ".wr_cycles"}, wr_total - wr0, exp_wr_cnt);
        check({tag, ".both_en"}, both_total - both0, 0);
        if (exp_wr_cnt == 1) check({tag, ".wr_addr"}, last_wr_addr, {2'b00, ea[31:2]});
    endtask

    task automatic run_model(input string tag, input logic st, input logic [2:0] f3,
                             input logic [31:0] base, input logic [11:0] off,
                             input logic [31:0] sd, input logic [4:0] rd);
        logic flt;
        logic [31:0] d;
        int lat;
        model_op(st, f3, base, off, sd, flt, d, lat);
        run_op(tag, st, f3, base, off, sd, rd, flt, d, lat);
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] base;
        logic [11:0] off;
        logic [31:0] sd;
        logic        flt;
        logic [31:0] data;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] base,
                                input logic [11:0] off, input logic [31:0] sd, input logic flt,
                                input logic [31:0] data, input int lat);
        vec_t v;
        v.st = st; v.f3 = f3; v.base = base; v.off = off; v.sd = sd;
        v.flt = flt; v.data = data; v.lat = lat;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic flt_m;
        logic [31:0] d_m;
        int lat_m, rd0, wr0, mism;
        bit seen;

        vecs.push_back(mk(1, 3'd2, 32'h100, 12'h004, 32'hDEAD_BEEF, 0, 32'h0, 2));
        vecs.push_back(mk(0, 3'd2, 32'h100, 12'h004, 32'h0,         0, 32'hDEAD_BEEF, 2));
        vecs.push_back(mk(1, 3'd2, 32'h100, 12'h004, 32'h1122_3344, 0, 32'h0, 2));
        vecs.push_back(mk(1, 3'd0, 32'h100, 12'h006, 32'h1234_56AB, 0, 32'h0, 3));
        vecs.push_back(mk(0, 3'd2, 32'h100, 12'h004, 32'h0,         0, 32'h11AB_3344, 2));
        vecs.push_back(mk(0, 3'd0, 32'h100, 12'h006, 32'h0,         0, 32'hFFFF_FFAB, 2));
        vecs.push_back(mk(0, 3'd4, 32'h100, 12'h006, 32'h0,         0, 32'h0000_00AB, 2));
        vecs.push_back(mk(0, 3'd0, 32'h100, 12'h004, 32'h0,         0, 32'h0000_0044, 2));
        vecs.push_back(mk(0, 3'd4, 32'h100, 12'h007, 32'h0,         0, 32'h0000_0011, 2));
        vecs.push_back(mk(1, 3'd2, 32'h100, 12'h000, 32'h5555_AAAA, 0, 32'h0, 2));
        vecs.push_back(mk(1, 3'd1, 32'h100, 12'h002, 32'hFFFF_8001, 0, 32'h0, 3));
        vecs.push_back(mk(0, 3'd2, 32'h100, 12'h000, 32'h0,         0, 32'h8001_AAAA, 2));
        vecs.push_back(mk(0, 3'd1, 32'h100, 12'h002, 32'h0,         0, 32'hFFFF_8001, 2));
        vecs.push_back(mk(0, 3'd5, 32'h100, 12'h002, 32'h0,         0, 32'h0000_8001, 2));
        vecs.push_back(mk(0, 3'd2, 32'h100, 12'h002, 32'h0,         1, 32'h0, 2));
        vecs.push_back(mk(1, 3'd1, 32'h100, 12'h001, 32'h1234,      1, 32'h0, 2));
        vecs.push_back(mk(0, 3'd2, 32'h1000, 12'h000, 32'h0,        1, 32'h0, 2));
        vecs.push_back(mk(1, 3'd4, 32'h100, 12'h000, 32'h0,         1, 32'h0, 2));
        vecs.push_back(mk(0, 3'd3, 32'h100, 12'h000, 32'h0,         1, 32'h0, 2));
        vecs.push_back(mk(1, 3'd2, 32'h0,   12'h004, 32'hCAFE_F00D, 0, 32'h0, 2));
        vecs.push_back(mk(0, 3'd2, 32'h8,   12'hFFC, 32'h0,         0, 32'hCAFE_F00D, 2));

        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);
        rst = 1'b0; fill = 1'b1; flush = 1'b0;
        drive(0, 3'd0, 32'h0, 12'h0, 32'h0, 5'd0);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.ready", req_ready, 1);
        check("reset.rd_en", mem_read_en, 0);
        check("reset.wr_en", mem_write_en, 0);
        check("reset.resp_valid", resp_valid, 0);
        check("reset.addr", mem_address, 0);
        check("reset.resp_data", resp_data, 0);
        fill = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        // Directed table; the model runs alongside so its memory stays in step.
        for (int i = 0; i < vecs.size(); i++) begin
            model_op(vecs[i].st, vecs[i].f3, vecs[i].base, vecs[i].off, vecs[i].sd, flt_m, d_m, lat_m);
            run_op($sformatf("vec%0d", i), vecs[i].st, vecs[i].f3, vecs[i].base, vecs[i].off,
                   vecs[i].sd, 5'(i), vecs[i].flt, vecs[i].data, vecs[i].lat);
        end

        // Flush during LOAD: aborted, no response.
        drive(0, 3'd2, 32'h100, 12'h004, 32'h0, 5'd7);
        @(negedge clk);
        req_valid = 1'b0;
        flush = 1'b1;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            flush = 1'b0;
            if (resp_valid) seen = 1;
        end
        check("flush_load.no_resp", seen, 0);
        check("flush_load.ready", req_ready, 1);

        // Flush in IDLE: request is not accepted.
        rd0 = rd_total;
        drive(0, 3'd2, 32'h100, 12'h004, 32'h0, 5'd8);
        flush = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        flush = 1'b0;
        check("flush_idle.ready", req_ready, 1);
        check("flush_idle.rd_en", mem_read_en, 0);
        @(negedge clk);
        check("flush_idle.rd_cycles", rd_total - rd0, 0);

        // Flush during the WRITE of an SB: write commits, response still issued.
        wr0 = wr_total;
        model_op(1, 3'd0, 32'h100, 12'h005, 32'h0000_00C3, flt_m, d_m, lat_m);
        drive(1, 3'd0, 32'h100, 12'h005, 32'h0000_00C3, 5'd9);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_write.resp_valid", resp_valid, 1);
        check("flush_write.is_store", resp_is_store, 1);
        check("flush_write.rd", resp_rd, 9);
        check("flush_write.wr_cycles", wr_total - wr0, 1);
        run_op("flush_write.readback", 0, 3'd2, 32'h100, 12'h004, 32'h0, 5'd10, 0, 32'h11AB_C344, 2);

        // Reset during MERGE: operation dropped, memory untouched.
        wr0 = wr_total;
        drive(1, 3'd0, 32'h100, 12'h004, 32'h0000_0077, 5'd11);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("rst_merge.ready", req_ready, 1);
        check("rst_merge.wr_en", mem_write_en, 0);
        check("rst_merge.resp_valid", resp_valid, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_merge.wr_cycles", wr_total - wr0, 0);
        run_model("rst_merge.readback", 0, 3'd2, 32'h100, 12'h004, 32'h0, 5'd12);

        // Random operations against the reference model.
        for (int n = 0; n < 300; n++) begin
            logic st;
            logic [2:0] f3;
            logic [31:0] base;
            logic [11:0] off;
            st   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            base = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(32'h100, 32'h17F));
            off  = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) begin
                base[1:0] = 2'b00;
                off[1:0]  = 2'b00;
            end
            run_model($sformatf("rnd%0d", n), st, f3, base, off, $urandom, 5'($urandom));
        end

        @(negedge clk);
        mism = 0;
        for (int i = 0; i < MEM_WORDS; i++) if (tb_mem[i] !== ref_mem[i]) mism++;
        check("final_mem_mismatch_words", mism, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
